// File: rtl/mod_pkg.sv
// Shared definitions for the modulo control unit: FSM state encoding and default counter width.
package mod_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SUB  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam int unsigned ITER_W_DEF = 32;

endpackage

// File: rtl/mod_iter_cnt.sv
// Subtraction iteration counter: synchronous clear, count enable, terminal-count flag at MAX_ITER.
module mod_iter_cnt
    import mod_pkg::*;
#(
    parameter int unsigned          ITER_W   = ITER_W_DEF,
    parameter logic [ITER_W-1:0]    MAX_ITER = {ITER_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    output logic [ITER_W-1:0] count,
    output logic              at_max
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // The controller never enables past the limit, so the count cannot wrap.
    assign at_max = (count == MAX_ITER);

endmodule

// File: rtl/mod_ctrl.sv
// Modulo controller: loads A into TEMP, then subtracts B until TEMP < B, reporting done or error.
module mod_ctrl
    import mod_pkg::*;
#(
    parameter int unsigned          ITER_W   = ITER_W_DEF,
    parameter logic [ITER_W-1:0]    MAX_ITER = {ITER_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              b_zero,
    input  logic              less_than_B,
    output logic              save_A,
    output logic              subtract,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ITER_W-1:0] iter_count,
    output logic [2:0]        state_dbg
);

    // Handshake: start is a request sampled only in IDLE (ignored otherwise, never queued);
    // exactly one of done/error pulses for one cycle per accepted request, and the datapath
    // result is valid only while done is high.

    state_t state;
    logic   cnt_clr;
    logic   cnt_at_max;

    assign cnt_clr  = (state == S_IDLE) && start && !b_zero;
    assign subtract = (state == S_SUB) && !less_than_B && !cnt_at_max;

    mod_iter_cnt #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (subtract),
        .count  (iter_count),
        .at_max (cnt_at_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= b_zero ? S_ERR : S_LOAD;
                    end
                end
                S_LOAD: state <= S_SUB;
                S_SUB: begin
                    if (less_than_B) begin
                        state <= S_DONE;
                    end else if (cnt_at_max) begin
                        state <= S_ERR;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign save_A    = (state == S_LOAD);
    assign busy      = (state == S_LOAD) || (state == S_SUB);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);
    assign state_dbg = state;

endmodule
